// File: rtl/display_pkg.sv
// Shared types and constants for the two-source 7-segment display arbiter.
// Holds owner-state encoding, anode patterns and default timing parameters.
package display_pkg;

    // Encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } owner_t;

    localparam logic [3:0] ANODE_OFF = 4'b1111;
    localparam logic [3:0] ANODE_D0  = 4'b0111;
    localparam logic [3:0] ANODE_D1  = 4'b1011;
    localparam logic [3:0] ANODE_D2  = 4'b1101;
    localparam logic [3:0] ANODE_D3  = 4'b1110;

    localparam int SCAN_DIV_DEFAULT     = 262144;
    localparam int BLANK_CYCLES_DEFAULT = 1024;
    localparam int DWELL_CYCLES_DEFAULT = 200000000;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        case (idx)
            2'd0:    return ANODE_D0;
            2'd1:    return ANODE_D1;
            2'd2:    return ANODE_D2;
            default: return ANODE_D3;
        endcase
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Digit-scan timebase: slot counter, digit index, blanking window and frame end.
// Outputs are combinational decodes of the counters; no backpressure.
module scan_timer
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEFAULT,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    output logic [1:0] digit_idx,
    output logic       blank,
    output logic       frame_end
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);

    logic [SLOT_W-1:0] slot_cnt;
    logic              slot_wrap;

    assign slot_wrap = (slot_cnt == SLOT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (slot_wrap) begin
            slot_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            slot_cnt  <= slot_cnt + SLOT_W'(1);
        end
    end

    assign blank     = (slot_cnt < SLOT_W'(BLANK_CYCLES));
    assign frame_end = slot_wrap && (digit_idx == 2'd3);

endmodule

// File: rtl/display_arbiter.sv
// Grants a 4-digit BCD display to the grade or alert source, switching only at frame ends.
// Outputs registered one cycle behind the scan counters. Option: SEG_LEADING_ZERO_BLANK_EN.
module display_arbiter
    import display_pkg::*;
#(
    parameter int SCAN_DIV     = SCAN_DIV_DEFAULT,
    parameter int BLANK_CYCLES = BLANK_CYCLES_DEFAULT,
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic [1:0]  gnt,
    output logic [3:0]  Anode_Activate,
    output logic [3:0]  digit_code
);

    localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);
    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYCLES);

    logic [1:0]         digit_idx;
    logic               blank;
    logic               frame_end;
    owner_t             state;
    owner_t             next_state;
    logic [DWELL_W-1:0] dwell;
    logic               dwell_done;
    logic [15:0]        snapshot;
    logic [15:0]        next_data;
    logic [3:0]         nibble;
    logic               lead_zero;

    scan_timer #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scan_timer (
        .clock     (clock),
        .reset     (reset),
        .digit_idx (digit_idx),
        .blank     (blank),
        .frame_end (frame_end)
    );

    assign dwell_done = (dwell >= DWELL_MAX);

    always_comb begin
        next_state = IDLE;
        if (state == OWN1 && !dwell_done) begin
            next_state = OWN1;
        end else if (req1) begin
            next_state = OWN1;
        end else if (req0) begin
            next_state = OWN0;
        end
    end

    always_comb begin
        next_data = 16'h0000;
        case (next_state)
            OWN0:    next_data = data0;
            OWN1:    next_data = data1;
            default: next_data = 16'h0000;
        endcase
    end

    always_comb begin
        nibble = snapshot[15:12];
        case (digit_idx)
            2'd1:    nibble = snapshot[11:8];
            2'd2:    nibble = snapshot[7:4];
            2'd3:    nibble = snapshot[3:0];
            default: nibble = snapshot[15:12];
        endcase
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        lead_zero = 1'b0;
        case (digit_idx)
            2'd0:    lead_zero = (snapshot[15:12] == 4'h0);
            2'd1:    lead_zero = (snapshot[15:8] == 8'h00);
            2'd2:    lead_zero = (snapshot[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase
    end
`else
    assign lead_zero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            dwell          <= '0;
            snapshot       <= 16'h0000;
            Anode_Activate <= ANODE_OFF;
            digit_code     <= 4'h0;
        end else begin
            if (frame_end) begin
                state    <= next_state;
                snapshot <= next_data;
            end
            if (frame_end && next_state == OWN1 && state != OWN1) begin
                dwell <= '0;
            end else if (state == OWN1 && !dwell_done) begin
                dwell <= dwell + DWELL_W'(1);
            end
            digit_code <= nibble;
            if (blank || state == IDLE || lead_zero) begin
                Anode_Activate <= ANODE_OFF;
            end else begin
                Anode_Activate <= anode_for(digit_idx);
            end
        end
    end

    assign gnt = state;

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized self-checking bench for display_arbiter against a time-based reference model.
module tb_display_arbiter;

    localparam int SD    = 8;
    localparam int BLANK = 2;
    localparam int DWELL = 64;
    localparam int FRAME = 4 * SD;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req0  = 1'b0;
    logic [15:0] data0 = 16'h0000;
    logic        req1  = 1'b0;
    logic [15:0] data1 = 16'h0000;
    logic [1:0]  gnt;
    logic [3:0]  Anode_Activate;
    logic [3:0]  digit_code;

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since reset, owner (0 idle, 1 grade, 2 alert), snapshot, dwell.
    int          m_t     = 0;
    int          m_owner = 0;
    int          m_dwell = 0;
    logic [15:0] m_snap  = 16'h0000;
    logic [1:0]  e_gnt;
    logic [3:0]  e_an;
    logic [3:0]  e_dc;

    display_arbiter #(
        .SCAN_DIV     (SD),
        .BLANK_CYCLES (BLANK),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req0           (req0),
        .data0          (data0),
        .req1           (req1),
        .data1          (data1),
        .gnt            (gnt),
        .Anode_Activate (Anode_Activate),
        .digit_code     (digit_code)
    );

    always #5 clock = ~clock;

    function automatic logic lead_zero(input int dig, input logic [15:0] snap);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        return (dig < 3) && ((snap >> (4 * (3 - dig))) == 16'h0000);
`else
        return 1'b0;
`endif
    endfunction

    // Advance one clock: compute what the DUT must show after this edge, then step past it.
    task automatic tick();
        int slot;
        int dig;
        int nxt;
        logic bnd;
        if (reset) begin
            m_t = 0; m_owner = 0; m_dwell = 0; m_snap = 16'h0000;
            e_gnt = 2'b00; e_an = 4'hF; e_dc = 4'h0;
        end else begin
            slot = m_t % SD;
            dig  = (m_t / SD) % 4;
            e_dc = 4'((m_snap >> (4 * (3 - dig))) & 16'h000F);
            e_an = (m_owner != 0 && slot >= BLANK && !lead_zero(dig, m_snap)) ?
                   ~(4'b1000 >> dig) : 4'hF;
            bnd  = ((m_t % FRAME) == FRAME - 1);
            nxt  = m_owner;
            if (bnd) begin
                if (m_owner == 2 && m_dwell < DWELL) nxt = 2;
                else if (req1) nxt = 2;
                else if (req0) nxt = 1;
                else nxt = 0;
            end
            if (bnd && nxt == 2 && m_owner != 2) m_dwell = 0;
            else if (m_owner == 2 && m_dwell < DWELL) m_dwell = m_dwell + 1;
            if (bnd) m_snap = (nxt == 2) ? data1 : (nxt == 1) ? data0 : 16'h0000;
            m_owner = nxt;
            m_t = m_t + 1;
            e_gnt = (nxt == 2) ? 2'b10 : (nxt == 1) ? 2'b01 : 2'b00;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1; data0 = 16'hFFFF; data1 = 16'hFFFF;
        repeat (3) begin
            tick();
            checks++;
            if (gnt !== 2'b00 || Anode_Activate !== 4'b1111 || digit_code !== 4'h0) begin
                errors++;
                $display("FAIL reset: gnt=%b an=%b dc=%h, want 00 1111 0", gnt, Anode_Activate, digit_code);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_idle();
        repeat (3 * FRAME) begin
            tick();
            checks++;
            if (gnt !== 2'b00 || Anode_Activate !== 4'b1111) begin
                errors++;
                $display("FAIL idle t=%0d: gnt=%b an=%b, want 00 1111", m_t, gnt, Anode_Activate);
            end
        end
    endtask

    task automatic test_grade();
        req0 = 1'b1; data0 = 16'h1234;
        repeat (3 * FRAME) begin
            tick();
            checks++;
            if (gnt !== e_gnt || Anode_Activate !== e_an || (e_an != 4'hF && digit_code !== e_dc)) begin
                errors++;
                $display("FAIL grade t=%0d: gnt=%b an=%b dc=%h, want %b %b %h",
                         m_t, gnt, Anode_Activate, digit_code, e_gnt, e_an, e_dc);
            end
        end
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL grade_gnt: gnt=%b, want 01", gnt);
        end
    endtask

    task automatic test_preempt();
        repeat (10) tick();
        req1 = 1'b1; data1 = 16'h0007;
        repeat (4 * FRAME) begin
            tick();
            checks++;
            if (gnt !== e_gnt || Anode_Activate !== e_an || (e_an != 4'hF && digit_code !== e_dc)) begin
                errors++;
                $display("FAIL preempt t=%0d: gnt=%b an=%b dc=%h, want %b %b %h",
                         m_t, gnt, Anode_Activate, digit_code, e_gnt, e_an, e_dc);
            end
        end
        checks++;
        if (gnt !== 2'b10) begin
            errors++;
            $display("FAIL preempt_gnt: gnt=%b, want 10", gnt);
        end
    endtask

    task automatic test_dwell();
        int own1_cycles;
        req1 = 1'b0; req0 = 1'b1; data0 = 16'h4321;
        repeat (4 * FRAME) tick();
        while ((m_t % FRAME) != FRAME - 1) tick();
        req1 = 1'b1; data1 = 16'h0056;
        tick();
        req1 = 1'b0;
        own1_cycles = (gnt === 2'b10) ? 1 : 0;
        repeat (5 * FRAME) begin
            tick();
            if (gnt === 2'b10) own1_cycles++;
            checks++;
            if (gnt !== e_gnt || Anode_Activate !== e_an || (e_an != 4'hF && digit_code !== e_dc)) begin
                errors++;
                $display("FAIL dwell t=%0d: gnt=%b an=%b dc=%h, want %b %b %h",
                         m_t, gnt, Anode_Activate, digit_code, e_gnt, e_an, e_dc);
            end
        end
        // Dwell reaches 64 only by the third boundary after entry: three frames held.
        checks++;
        if (own1_cycles != 3 * FRAME) begin
            errors++;
            $display("FAIL dwell_len: held %0d cycles, want %0d", own1_cycles, 3 * FRAME);
        end
        checks++;
        if (gnt !== 2'b01) begin
            errors++;
            $display("FAIL dwell_release: gnt=%b, want 01", gnt);
        end
    endtask

    task automatic test_snapshot();
        req1 = 1'b0; req0 = 1'b1; data0 = 16'h1234;
        for (int i = 0; i < 10 * FRAME && !(m_owner == 1 && m_snap == 16'h1234 && (m_t % FRAME) == 10); i++)
            tick();
        data0 = 16'h9999;
        repeat (2 * FRAME) begin
            tick();
            checks++;
            if (gnt !== e_gnt || Anode_Activate !== e_an || (e_an != 4'hF && digit_code !== e_dc)) begin
                errors++;
                $display("FAIL snapshot t=%0d: gnt=%b an=%b dc=%h, want %b %b %h",
                         m_t, gnt, Anode_Activate, digit_code, e_gnt, e_an, e_dc);
            end
        end
    endtask

    task automatic test_reset_mid();
        int first_vis;
        logic [3:0] first_an;
        req1 = 1'b1; data1 = 16'(($urandom % 9000) + 1000);
        for (int i = 0; i < 3 * FRAME && m_owner != 2; i++) tick();
        for (int i = 0; i < FRAME && (m_t % FRAME) != 2 * SD + 5; i++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if (gnt !== 2'b00 || Anode_Activate !== 4'b1111) begin
            errors++;
            $display("FAIL reset_mid: gnt=%b an=%b, want 00 1111", gnt, Anode_Activate);
        end
        reset = 1'b0;
        first_vis = -1;
        first_an  = 4'hF;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (first_vis < 0 && Anode_Activate !== 4'b1111) begin
                first_vis = i;
                first_an  = Anode_Activate;
            end
            checks++;
            if (gnt !== e_gnt || Anode_Activate !== e_an || (e_an != 4'hF && digit_code !== e_dc)) begin
                errors++;
                $display("FAIL restart t=%0d: gnt=%b an=%b dc=%h, want %b %b %h",
                         m_t, gnt, Anode_Activate, digit_code, e_gnt, e_an, e_dc);
            end
        end
        checks++;
        if (first_vis != FRAME + BLANK || first_an !== 4'b0111) begin
            errors++;
            $display("FAIL restart_first: cycle %0d anode %b, want %0d 0111",
                     first_vis, first_an, FRAME + BLANK);
        end
    endtask

    task automatic test_random();
        req1 = 1'b0;
        repeat (12 * FRAME) begin
            if ($urandom % 16 == 0) req0 = ~req0;
            if ($urandom % 40 == 0) req1 = ~req1;
            if ($urandom % 5 == 0) data0 = 16'($urandom);
            if ($urandom % 5 == 0) data1 = 16'($urandom);
            tick();
            checks++;
            if (gnt !== e_gnt || Anode_Activate !== e_an || (e_an != 4'hF && digit_code !== e_dc)) begin
                errors++;
                $display("FAIL random t=%0d: gnt=%b an=%b dc=%h, want %b %b %h",
                         m_t, gnt, Anode_Activate, digit_code, e_gnt, e_an, e_dc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_grade();
        test_preempt();
        test_dwell();
        test_snapshot();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
